// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and a frame-length helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, free-running bit phase counter and 3-sample majority
// vote around the bit centre. Usable standalone by rate-detection logic.
module uart_rx_sampler #(
  parameter int unsigned Oversample = 4,
  parameter logic        IdleLevel  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic phase_clr_i,
  input  logic line_i,
  output logic line_o,
  output logic vote_o,
  output logic decide_o
);

  localparam int unsigned M = (1 << (Oversample - 1)) - 1;
  localparam logic [Oversample-1:0] PhLo  = Oversample'(M - 1);
  localparam logic [Oversample-1:0] PhMid = Oversample'(M);
  localparam logic [Oversample-1:0] PhHi  = Oversample'(M + 1);

  logic                  sync1_q, sync2_q;
  logic                  samp_lo_q, samp_mid_q;
  logic [Oversample-1:0] phase_q;
  logic [Oversample-1:0] phase_now;

  // phase_now is the phase this tick represents; a start-detect tick is phase 0
  always_comb begin
    phase_now = phase_clr_i ? '0 : phase_q + Oversample'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= IdleLevel;
      sync2_q    <= IdleLevel;
      phase_q    <= '0;
      samp_lo_q  <= IdleLevel;
      samp_mid_q <= IdleLevel;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      if (tick_i) begin
        phase_q <= phase_now;
        if (phase_now == PhLo)  samp_lo_q  <= sync2_q;
        if (phase_now == PhMid) samp_mid_q <= sync2_q;
      end
    end
  end

  assign line_o   = sync2_q;
  assign decide_o = tick_i && (phase_now == PhHi);
  assign vote_o   = (samp_lo_q & samp_mid_q) | (samp_lo_q & sync2_q) | (samp_mid_q & sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: parity, 1/2 stop bits, line
// polarity, framing/parity error pulses and break hold-off.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DataBits   = 8,
  parameter int unsigned Oversample = 4,
  parameter int unsigned Parity     = 0,
  parameter int unsigned StopBits   = 1,
  parameter int unsigned Invert     = 1
) (
  input  logic                ref_clk,
  input  logic                reset,
  input  logic                samp_clk,
  input  logic                in,
  output logic [DataBits-1:0] out,
  output logic                busy,
  output logic                ready,
  output logic                frame_err,
  output logic                parity_err,
  output logic                bit_clk
);

  localparam logic InvBit   = (Invert != 0) ? 1'b1 : 1'b0;
  localparam logic StartLvl = InvBit;
  localparam logic IdleLvl  = ~InvBit;
  localparam int unsigned IdxW = $clog2(DataBits);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);
  localparam logic StopLast = (StopBits == 2) ? 1'b1 : 1'b0;

  rx_state_e             state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic [DataBits-1:0]   shift_q, shift_d;
  logic [DataBits-1:0]   out_q, out_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_err_q, par_err_d;
  logic                  ready_q, ready_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic                  bclk_q, bclk_d;

  logic line, vote, decide, phase_clr, dbit;

  uart_rx_sampler #(
    .Oversample (Oversample),
    .IdleLevel  (IdleLvl)
  ) u_sampler (
    .clk_i       (ref_clk),
    .rst_i       (reset),
    .tick_i      (samp_clk),
    .phase_clr_i (phase_clr),
    .line_i      (in),
    .line_o      (line),
    .vote_o      (vote),
    .decide_o    (decide)
  );

  // Parity bit shares the data polarity, so it is de-inverted like the data
  assign dbit = vote ^ InvBit;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    out_d     = out_q;
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    bclk_d    = 1'b0;
    phase_clr = 1'b0;
    if (samp_clk) begin
      if (decide && (state_q inside {START, DATA, PARITY, STOP})) bclk_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (line == StartLvl) begin
            phase_clr = 1'b1;
            state_d   = START;
          end
        end
        START: begin
          if (decide) begin
            if (vote != StartLvl) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              idx_d     = '0;
              stop_d    = 1'b0;
              par_acc_d = 1'b0;
              par_err_d = 1'b0;
            end
          end
        end
        DATA: begin
          if (decide) begin
            shift_d[idx_q] = dbit;
            par_acc_d      = par_acc_q ^ dbit;
            if (idx_q == IdxLast) state_d = (Parity != PAR_NONE) ? PARITY : STOP;
            else                  idx_d   = idx_q + IdxW'(1);
          end
        end
        PARITY: begin
          if (decide) begin
            par_err_d = (Parity == PAR_ODD) ? ~(par_acc_q ^ dbit) : (par_acc_q ^ dbit);
            state_d   = STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (vote != IdleLvl) begin
              ready_d = 1'b1;
              ferr_d  = 1'b1;
              perr_d  = par_err_q;
              out_d   = shift_q;
              state_d = BREAK;
            end else if (stop_q == StopLast) begin
              ready_d = 1'b1;
              perr_d  = par_err_q;
              out_d   = shift_q;
              state_d = IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
        BREAK: begin
          if (line == IdleLvl) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      out_q     <= '0;
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      bclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      bclk_q    <= bclk_d;
    end
  end

  assign out        = out_q;
  assign busy       = (state_q != IDLE);
  assign ready      = ready_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign bit_clk    = bclk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three builds (8N1, 8E1, 7N2), all with
// inverted line polarity (idle low, start high, data inverted on the wire).
module tb_uart_rx_cfg;

  logic       ref_clk = 1'b0;
  logic       samp_clk;
  logic [2:0] line, rst, rdy, fe, pe, bsy, bclk;
  logic [7:0] out_a, out_p;
  logic [6:0] out_s;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  int unsigned rdy_n [3];
  int unsigned bclk_n [3];
  int unsigned orphan_n [3];
  logic [8:0]  last_out [3];
  logic        last_fe [3];
  logic        last_pe [3];
  logic        last_busy [3];

  always #5 ref_clk = ~ref_clk;

  uart_rx_cfg dut_a (
    .ref_clk(ref_clk), .reset(rst[0]), .samp_clk(samp_clk), .in(line[0]),
    .out(out_a), .busy(bsy[0]), .ready(rdy[0]), .frame_err(fe[0]),
    .parity_err(pe[0]), .bit_clk(bclk[0])
  );

  uart_rx_cfg #(.Parity(2)) dut_p (
    .ref_clk(ref_clk), .reset(rst[1]), .samp_clk(samp_clk), .in(line[1]),
    .out(out_p), .busy(bsy[1]), .ready(rdy[1]), .frame_err(fe[1]),
    .parity_err(pe[1]), .bit_clk(bclk[1])
  );

  uart_rx_cfg #(.DataBits(7), .StopBits(2)) dut_s (
    .ref_clk(ref_clk), .reset(rst[2]), .samp_clk(samp_clk), .in(line[2]),
    .out(out_s), .busy(bsy[2]), .ready(rdy[2]), .frame_err(fe[2]),
    .parity_err(pe[2]), .bit_clk(bclk[2])
  );

  // Pulse monitor, sampled mid-cycle
  always @(negedge ref_clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy[d]) begin
        rdy_n[d]++;
        last_out[d]  = (d == 0) ? {1'b0, out_a} : (d == 1) ? {1'b0, out_p} : {2'b00, out_s};
        last_fe[d]   = fe[d];
        last_pe[d]   = pe[d];
        last_busy[d] = bsy[d];
      end
      if (bclk[d]) bclk_n[d]++;
      if ((fe[d] || pe[d]) && !rdy[d]) orphan_n[d]++;
    end
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after cyc clocks
  task automatic drive(input int d, input logic lv, input int cyc);
    line[d] = lv;
    repeat (cyc) begin
      @(posedge ref_clk);
      #1;
    end
  endtask

  task automatic send_body(input int d, input int nb, input logic [8:0] data,
                           input int par, input int nstop, input logic [1:0] stop_ok,
                           input int spike_bit, input int stall_bit);
    logic lv;
    for (int i = 0; i < nb; i++) begin
      lv = ~data[i];
      if (i == spike_bit) begin
        drive(d, lv, 7);
        drive(d, ~lv, 1);
        drive(d, lv, 8);
      end else if (i == stall_bit) begin
        drive(d, lv, 4);
        samp_clk = 1'b0;
        drive(d, lv, 40);
        chk("stall_busy", bsy[d], 1);
        samp_clk = 1'b1;
        drive(d, lv, 12);
      end else begin
        drive(d, lv, 16);
      end
    end
    if (par >= 0) drive(d, ~par[0], 16);
    for (int s = 0; s < nstop; s++) drive(d, stop_ok[s] ? 1'b0 : 1'b1, 16);
    line[d] = 1'b0;
  endtask

  task automatic send(input int d, input int nb, input logic [8:0] data,
                      input int par, input int nstop, input logic [1:0] stop_ok,
                      input int spike_bit, input int stall_bit);
    drive(d, 1'b1, 16);
    send_body(d, nb, data, par, nstop, stop_ok, spike_bit, stall_bit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r0, b0;
    line     = 3'b000;
    rst      = 3'b111;
    samp_clk = 1'b1;
    repeat (4) @(posedge ref_clk);
    #1;
    rst = 3'b000;
    drive(0, 1'b0, 4);

    // Reset state
    chk("rst_out_a", out_a, 0);
    chk("rst_busy_a", bsy[0], 0);
    chk("rst_ready_a", rdy[0], 0);
    chk("rst_errs_a", {fe[0], pe[0]}, 0);
    chk("rst_bitclk_a", bclk[0], 0);
    chk("rst_out_s", out_s, 0);

    // 1: 8N1 0xA5, busy latency
    drive(0, 1'b1, 1);
    chk("t1_busy_early", bsy[0], 0);
    drive(0, 1'b1, 2);
    chk("t1_busy_rise", bsy[0], 1);
    drive(0, 1'b1, 13);
    send_body(0, 8, 9'h0A5, -1, 1, 2'b11, -1, -1);
    drive(0, 1'b0, 16);
    chk("t1_ready_cnt", rdy_n[0], 1);
    chk("t1_out", last_out[0], 'hA5);
    chk("t1_errs", {last_fe[0], last_pe[0]}, 0);
    chk("t1_busy_at_ready", last_busy[0], 0);
    chk("t1_bitclk_cnt", bclk_n[0], 10);

    // 2: 8E1, good parity (with samp_clk stall), then bad parity
    send(1, 8, 9'h03C, 0, 1, 2'b11, -1, 2);
    drive(1, 1'b0, 16);
    chk("t2_ready_cnt", rdy_n[1], 1);
    chk("t2_out_good", last_out[1], 'h3C);
    chk("t2_perr_good", last_pe[1], 0);
    chk("t2_bitclk_cnt", bclk_n[1], 11);
    send(1, 8, 9'h03C, 1, 1, 2'b11, -1, -1);
    drive(1, 1'b0, 16);
    chk("t2_ready_cnt2", rdy_n[1], 2);
    chk("t2_out_bad", last_out[1], 'h3C);
    chk("t2_perr_bad", last_pe[1], 1);
    chk("t2_ferr_bad", last_fe[1], 0);

    // 3: framing error, held break, recovery
    r0 = rdy_n[0];
    send(0, 8, 9'h012, -1, 1, 2'b00, -1, -1);
    drive(0, 1'b1, 640);
    chk("t3_ready_cnt", rdy_n[0] - r0, 1);
    chk("t3_ferr", last_fe[0], 1);
    chk("t3_perr", last_pe[0], 0);
    chk("t3_out", last_out[0], 'h12);
    chk("t3_busy_at_ready", last_busy[0], 1);
    chk("t3_busy_break", bsy[0], 1);
    drive(0, 1'b0, 16);
    chk("t3_busy_idle", bsy[0], 0);
    send(0, 8, 9'h055, -1, 1, 2'b11, -1, -1);
    drive(0, 1'b0, 16);
    chk("t3_ready_cnt2", rdy_n[0] - r0, 2);
    chk("t3_out2", last_out[0], 'h55);
    chk("t3_errs2", {last_fe[0], last_pe[0]}, 0);

    // 4: 3-tick start glitch
    r0 = rdy_n[0];
    b0 = bclk_n[0];
    drive(0, 1'b1, 3);
    drive(0, 1'b0, 7);
    chk("t4_busy_before", bsy[0], 1);
    drive(0, 1'b0, 1);
    chk("t4_busy_after", bsy[0], 0);
    drive(0, 1'b0, 32);
    chk("t4_no_ready", rdy_n[0] - r0, 0);
    chk("t4_bitclk", bclk_n[0] - b0, 1);

    // 5: single-tick spike at phase M on data bit 3
    send(0, 8, 9'h0F0, -1, 1, 2'b11, 3, -1);
    drive(0, 1'b0, 16);
    chk("t5_ready_cnt", rdy_n[0] - r0, 1);
    chk("t5_out", last_out[0], 'hF0);
    chk("t5_errs", {last_fe[0], last_pe[0]}, 0);

    // 6: 7N2 build; bad second stop; mid-frame reset; recovery
    send(2, 7, 9'h02A, -1, 2, 2'b11, -1, -1);
    drive(2, 1'b0, 16);
    chk("t6_ready_cnt", rdy_n[2], 1);
    chk("t6_out_pre", last_out[2], 'h2A);
    chk("t6_errs_pre", {last_fe[2], last_pe[2]}, 0);
    send(2, 7, 9'h015, -1, 2, 2'b01, -1, -1);
    drive(2, 1'b0, 16);
    chk("t6_ready_stop2", rdy_n[2], 2);
    chk("t6_ferr_stop2", last_fe[2], 1);
    chk("t6_out_stop2", last_out[2], 'h15);
    chk("t6_busy_idle", bsy[2], 0);
    drive(2, 1'b1, 16);
    for (int i = 0; i < 4; i++) drive(2, ~(i == 0 || i == 2), 16);
    drive(2, 1'b1, 8);
    chk("t6_busy_mid", bsy[2], 1);
    rst[2] = 1'b1;
    drive(2, 1'b0, 1);
    rst[2] = 1'b0;
    chk("t6_busy_rst", bsy[2], 0);
    chk("t6_out_rst", out_s, 0);
    drive(2, 1'b0, 48);
    chk("t6_no_ready", rdy_n[2], 2);
    send(2, 7, 9'h081, -1, 2, 2'b11, -1, -1);
    drive(2, 1'b0, 16);
    chk("t6_ready_post", rdy_n[2], 3);
    chk("t6_out_post", last_out[2], 'h01);
    chk("t6_errs_post", {last_fe[2], last_pe[2]}, 0);

    chk("orphan_err_pulses", orphan_n[0] + orphan_n[1] + orphan_n[2], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
